// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding,
// one-hot grant constants, default bus widths and small helpers.
package bus_arbiter_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SEL_W   = 4;
    localparam int DEF_TIMEOUT = 255;

    // Arbiter ownership state. The encoding doubles as the one-hot grant.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // Map an ownership state to the debug grant vector.
    function automatic logic [1:0] grant_of(input arb_state_e state);
        logic [1:0] grant;
        case (state)
            OWN0:    grant = GRANT_M0;
            OWN1:    grant = GRANT_M1;
            default: grant = GRANT_NONE;
        endcase
        return grant;
    endfunction

    // Index (0 or 1) of the master owning the bus in an OWN state.
    function automatic logic owner_idx(input arb_state_e state);
        logic idx;
        case (state)
            OWN1:    idx = 1'b1;
            default: idx = 1'b0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin pick from IDLE: a lone requester wins, a tie goes to the
// master that did not own the bus last, no request keeps the arbiter idle.
module bus_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output arb_state_e next_state
);

    // Select the next owner from the current requests and last owner.
    always_comb begin
        next_state = IDLE;
        case ({req1, req0})
            2'b01: next_state = OWN0;
            2'b10: next_state = OWN1;
            2'b11: begin
                if (last) begin
                    next_state = OWN0;
                end else begin
                    next_state = OWN1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master to one-slave Wishbone arbiter. Master 0 is the data port,
// master 1 the instruction fetch. Ownership is decided in a registered
// IDLE cycle and held until ack, abort (cyc dropped) or watchdog expiry.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    input  logic [SEL_W-1:0]  m0_select_i,
    input  logic              m0_we_i,
    input  logic              m0_stb_i,
    input  logic              m0_cyc_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    input  logic [SEL_W-1:0]  m1_select_i,
    input  logic              m1_we_i,
    input  logic              m1_stb_i,
    input  logic              m1_cyc_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    output logic [SEL_W-1:0]  s_select_o,
    output logic              s_we_o,
    output logic              s_stb_o,
    output logic              s_cyc_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i,

    output logic [1:0]        grant_o
);

    // Timer only needs to reach TIMEOUT-1; keep at least one bit.
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);

    arb_state_e         state_r;
    logic               last_r;
    logic [TIMER_W-1:0] timer_r;

    logic               req0_s;
    logic               req1_s;
    arb_state_e         pick_s;
    logic               own_cyc_s;
    logic               owning_s;
    logic               timeout_s;

    assign req0_s = m0_cyc_i & m0_stb_i;
    assign req1_s = m1_cyc_i & m1_stb_i;

    bus_rr_pick u_pick (
        .req0       (req0_s),
        .req1       (req1_s),
        .last       (last_r),
        .next_state (pick_s)
    );

    // Cycle line of the current owner, used for abort and timeout gating.
    always_comb begin
        own_cyc_s = 1'b0;
        owning_s  = 1'b0;
        case (state_r)
            OWN0: begin
                own_cyc_s = m0_cyc_i;
                owning_s  = 1'b1;
            end
            OWN1: begin
                own_cyc_s = m1_cyc_i;
                owning_s  = 1'b1;
            end
            default: begin
                own_cyc_s = 1'b0;
                owning_s  = 1'b0;
            end
        endcase
    end

    // Watchdog fires on the last allowed cycle; an ack or an abort in the
    // same cycle takes precedence so no error is reported.
    always_comb begin
        if (owning_s && own_cyc_s && !s_ack_i && (timer_r == TIMER_MAX)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Ownership FSM, round-robin history and watchdog timer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            timer_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= pick_s;
                    timer_r <= '0;
                end
                OWN0, OWN1: begin
                    if (s_ack_i || !own_cyc_s || timeout_s) begin
                        state_r <= IDLE;
                        last_r  <= owner_idx(state_r);
                        timer_r <= '0;
                    end else if (timer_r != TIMER_MAX) begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end else begin
                        timer_r <= timer_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    timer_r <= '0;
                end
            endcase
        end
    end

    // Route the owner's request to the slave and the slave response back
    // to the owner only; everything else stays quiet. The watchdog cycle
    // withdraws cyc/stb so the slave sees the transfer abandoned.
    always_comb begin
        s_addr_o   = '0;
        s_data_o   = '0;
        s_select_o = '0;
        s_we_o     = 1'b0;
        s_stb_o    = 1'b0;
        s_cyc_o    = 1'b0;
        m0_data_o  = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_data_o  = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        grant_o    = grant_of(state_r);
        case (state_r)
            OWN0: begin
                s_addr_o   = m0_addr_i;
                s_data_o   = m0_data_i;
                s_select_o = m0_select_i;
                s_we_o     = m0_we_i;
                s_stb_o    = m0_stb_i & ~timeout_s;
                s_cyc_o    = m0_cyc_i & ~timeout_s;
                m0_data_o  = s_data_i;
                m0_ack_o   = s_ack_i;
                m0_err_o   = timeout_s;
            end
            OWN1: begin
                s_addr_o   = m1_addr_i;
                s_data_o   = m1_data_i;
                s_select_o = m1_select_i;
                s_we_o     = m1_we_i;
                s_stb_o    = m1_stb_i & ~timeout_s;
                s_cyc_o    = m1_cyc_i & ~timeout_s;
                m1_data_o  = s_data_i;
                m1_ack_o   = s_ack_i;
                m1_err_o   = timeout_s;
            end
            default: begin
                grant_o = GRANT_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with TIMEOUT = 4. Inputs change shortly
// after each rising edge; outputs are checked mid-cycle.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
    logic [3:0]  m0_select_i, m1_select_i;
    logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
    logic [31:0] m0_data_o, m1_data_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic [3:0]  s_select_o;
    logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
    logic [1:0]  grant_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_select_i(m0_select_i),
        .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_select_i(m1_select_i),
        .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_select_o(s_select_o),
        .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [1:0] exp_g [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    initial begin
        rst = 1'b0;
        m0_addr_i = 32'h0000_0100; m0_data_i = 32'h0; m0_select_i = 4'hF; m0_we_i = 1'b0;
        m1_addr_i = 32'h0000_0200; m1_data_i = 32'h0; m1_select_i = 4'hF; m1_we_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        s_ack_i = 1'b1; s_data_i = 32'h1234_5678;

        // Reset held 3 cycles with both requesting and a stray slave ack.
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check("rst_grant", {30'd0, grant_o}, 32'd0);
            check("rst_s_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
            check("rst_s_addr", s_addr_o, 32'd0);
            check("rst_acks", {28'd0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 32'd0);
            check("rst_mdata", m0_data_o | m1_data_o, 32'd0);
        end
        tick(); rst = 1'b1; s_ack_i = 1'b0; s_data_i = 32'h0; settle();
        check("rel_idle_grant", {30'd0, grant_o}, 32'd0);
        tick(); settle();
        check("rel_grant_m0", {30'd0, grant_o}, 32'd1);
        check("rel_s_addr", s_addr_o, 32'h0000_0100);
        s_ack_i = 1'b1; settle();
        check("rel_m0_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd2);
        tick(); s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; settle();
        check("rel_back_idle", {30'd0, grant_o}, 32'd0);

        // Single read by m1, acked in its second OWN1 cycle.
        m1_addr_i = 32'h0000_0010; m1_cyc_i = 1'b1; m1_stb_i = 1'b1; settle();
        check("rd_registered", {30'd0, grant_o, s_stb_o}, 32'd0);
        tick(); settle();
        check("rd_grant", {30'd0, grant_o}, 32'd2);
        check("rd_s_addr", s_addr_o, 32'h0000_0010);
        check("rd_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd3);
        check("rd_no_ack_yet", {31'd0, m1_ack_o}, 32'd0);
        tick(); s_ack_i = 1'b1; s_data_i = 32'hDEAD_BEEF; settle();
        check("rd_m1_ack", {31'd0, m1_ack_o}, 32'd1);
        check("rd_m1_data", m1_data_o, 32'hDEAD_BEEF);
        check("rd_m0_quiet", {31'd0, m0_ack_o}, 32'd0);
        check("rd_m0_data", m0_data_o, 32'd0);
        tick(); s_ack_i = 1'b0; s_data_i = 32'h0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; settle();
        check("rd_idle", {30'd0, grant_o}, 32'd0);

        // Contention: both request continuously, slave acks immediately.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            s_ack_i = (exp_g[i] != 2'b00);
            settle();
            check("rr_grant", {30'd0, grant_o}, {30'd0, exp_g[i]});
            check("rr_acks", {30'd0, m1_ack_o, m0_ack_o}, {30'd0, exp_g[i]});
        end
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;

        // Write pass-through from m0 while m1 waits.
        m0_addr_i = 32'h0000_0080; m0_data_i = 32'h0000_00A5; m0_select_i = 4'b0001; m0_we_i = 1'b1;
        m1_addr_i = 32'h0000_0044; m1_we_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick(); settle();
        check("wr_grant", {30'd0, grant_o}, 32'd1);
        check("wr_s_addr", s_addr_o, 32'h0000_0080);
        check("wr_s_data", s_data_o, 32'h0000_00A5);
        check("wr_s_sel_we", {27'd0, s_select_o, s_we_o}, {27'd0, 4'b0001, 1'b1});
        check("wr_s_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd3);
        tick(); s_ack_i = 1'b1; settle();
        check("wr_m1_held", {30'd0, grant_o}, 32'd1);
        check("wr_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd1);
        tick(); s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; settle();
        check("wr_idle", {30'd0, grant_o}, 32'd0);
        tick(); settle();
        check("wr_m1_grant", {30'd0, grant_o}, 32'd2);
        check("wr_m1_addr", s_addr_o, 32'h0000_0044);
        check("wr_m1_we", {31'd0, s_we_o}, 32'd0);
        s_ack_i = 1'b1; settle();
        check("wr_m1_ack", {31'd0, m1_ack_o}, 32'd1);
        tick(); s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; settle();

        // Timeout: slave never acks m0; m1 pending is served next.
        m0_addr_i = 32'h0000_0300;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(); settle();
            check("to_grant", {30'd0, grant_o}, 32'd1);
            check("to_no_err", {31'd0, m0_err_o}, 32'd0);
            check("to_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd3);
        end
        tick(); settle();
        check("to_err", {30'd0, m1_err_o, m0_err_o}, 32'd1);
        check("to_stb_off", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
        check("to_no_ack", {31'd0, m0_ack_o}, 32'd0);
        tick(); settle();
        check("to_idle", {30'd0, grant_o}, 32'd0);
        check("to_err_pulse", {31'd0, m0_err_o}, 32'd0);
        tick(); settle();
        check("to_m1_next", {30'd0, grant_o}, 32'd2);
        s_ack_i = 1'b1; settle();
        check("to_m1_ack", {31'd0, m1_ack_o}, 32'd1);
        tick(); s_ack_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; settle();

        // Ack landing on the watchdog cycle: ack wins, no error.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        repeat (3) tick();
        tick(); s_ack_i = 1'b1; s_data_i = 32'h0000_5A5A; settle();
        check("tie_ack", {30'd0, m0_ack_o, m0_err_o}, 32'd2);
        check("tie_stb", {31'd0, s_stb_o}, 32'd1);
        check("tie_data", m0_data_o, 32'h0000_5A5A);
        tick(); s_ack_i = 1'b0; s_data_i = 32'h0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; settle();
        check("tie_idle", {30'd0, grant_o}, 32'd0);

        // Abort: m1 drops cyc in its second OWN1 cycle.
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick(); settle();
        check("ab_grant", {30'd0, grant_o}, 32'd2);
        tick(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0; settle();
        check("ab_no_resp", {30'd0, m1_ack_o, m1_err_o}, 32'd0);
        check("ab_s_cyc", {31'd0, s_cyc_o}, 32'd0);
        tick(); settle();
        check("ab_idle", {30'd0, grant_o}, 32'd0);

        // Reset during OWN0, then a late slave ack.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick(); settle();
        check("mr_grant", {30'd0, grant_o}, 32'd1);
        rst = 1'b0;
        tick(); s_ack_i = 1'b1; settle();
        check("mr_grant_off", {30'd0, grant_o}, 32'd0);
        check("mr_no_ack", {31'd0, m0_ack_o}, 32'd0);
        check("mr_s_cyc", {31'd0, s_cyc_o}, 32'd0);
        tick(); settle();
        check("mr_still_no_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        rst = 1'b1; s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick(); settle();
        check("mr_final_idle", {30'd0, grant_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
